// File: rtl/crc32_rx_check_if.sv
// RX beat bus from the MAC framer into the FCS checker.
interface crc32_rx_check_if #(
  parameter int DATA_BYTES = 4
);
  localparam int LW = $clog2(DATA_BYTES) + 1;

  logic                    s_valid;
  logic [8*DATA_BYTES-1:0] s_data;
  logic                    s_sof;
  logic                    s_eof;
  logic [LW-1:0]           s_last_cnt;

  modport master (output s_valid, s_data, s_sof, s_eof, s_last_cnt);
  modport slave  (input  s_valid, s_data, s_sof, s_eof, s_last_cnt);
endinterface

// File: rtl/crc32_rx_check.sv
// Ethernet FCS checker, DATA_BYTES per beat, one verdict pulse per frame.
// Optional good/bad frame counters under `define CRC_STATS_EN.
module crc32_lane (
  input  logic        en,
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);
  localparam logic [31:0] POLY = 32'hEDB8_8320;
  logic [31:0] c;

  always_comb begin
    c = crc_in;
    if (en) begin
      c = crc_in ^ {24'd0, data};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

module crc32_rx_check #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int MIN_BYTES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  crc32_rx_check_if.slave      s,
  output logic                 res_valid,
  output logic                 res_ok,
  output logic [CNT_WIDTH-1:0] good_cnt,
  output logic [CNT_WIDTH-1:0] bad_cnt
);
  localparam int LW = $clog2(DATA_BYTES) + 1;
  localparam int CW = $clog2(MIN_BYTES + DATA_BYTES + 1);
  localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  typedef enum logic {IDLE, IN_FRAME} state_t;
  state_t state, state_nxt;

  logic [31:0]   crc_reg;
  logic [CW-1:0] byte_cnt;

  logic                          accept;
  logic [LW-1:0]                 last_eff;
  logic [DATA_BYTES-1:0]         lane_en;
  logic [DATA_BYTES:0][31:0]     crc_chain;
  logic [31:0]                   crc_next;
  logic [CW-1:0]                 nbytes, cnt_base, cnt_sum, cnt_next;

  // sof always wins: it restarts a frame whether we were idle or mid-frame
  assign accept = s.s_valid & (s.s_sof | (state == IN_FRAME));

  always_comb begin
    last_eff = s.s_last_cnt;
    if (s.s_last_cnt == '0 || s.s_last_cnt > LW'(DATA_BYTES))
      last_eff = LW'(DATA_BYTES);
  end

  assign crc_chain[0] = s.s_sof ? INIT : crc_reg;

  genvar i;
  generate
    for (i = 0; i < DATA_BYTES; i++) begin : g_lane
      assign lane_en[i] = ~s.s_eof | (LW'(i) < last_eff);
      crc32_lane u_lane (
        .en      (lane_en[i]),
        .data    (s.s_data[8*i +: 8]),
        .crc_in  (crc_chain[i]),
        .crc_out (crc_chain[i+1])
      );
    end
  endgenerate

  assign crc_next = crc_chain[DATA_BYTES];

  // length only matters up to MIN_BYTES, so the counter saturates there
  always_comb begin
    nbytes   = s.s_eof ? CW'(last_eff) : CW'(DATA_BYTES);
    cnt_base = s.s_sof ? '0 : byte_cnt;
    cnt_sum  = cnt_base + nbytes;
    cnt_next = (cnt_sum >= CW'(MIN_BYTES)) ? CW'(MIN_BYTES) : cnt_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s.s_eof ? IDLE : IN_FRAME;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg   <= INIT;
      byte_cnt  <= '0;
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
    end else begin
      res_valid <= accept & s.s_eof;
      if (accept) begin
        if (s.s_eof) begin
          res_ok   <= (crc_next == RESIDUE) && (cnt_next >= CW'(MIN_BYTES));
          crc_reg  <= INIT;
          byte_cnt <= '0;
        end else begin
          crc_reg  <= crc_next;
          byte_cnt <= cnt_next;
        end
      end
    end
  end

`ifdef CRC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (res_valid) begin
      if (res_ok  && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (!res_ok && bad_cnt  != '1) bad_cnt  <= bad_cnt + 1'b1;
    end
  end
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif
endmodule

// File: tb/tb_crc32_rx_check.sv
// Directed bench for crc32_rx_check, DATA_BYTES=4, CNT_WIDTH=2.
module tb_crc32_rx_check;
  localparam int DB   = 4;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crc32_rx_check_if #(.DATA_BYTES(DB)) s_if ();
  logic            res_valid, res_ok;
  logic [CNTW-1:0] good_cnt, bad_cnt;

  crc32_rx_check #(.DATA_BYTES(DB), .CNT_WIDTH(CNTW), .MIN_BYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s_if.slave),
    .res_valid (res_valid),
    .res_ok    (res_ok),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  int n_chk = 0, n_fail = 0, n_pulse = 0;
  int m_good = 0, m_bad = 0;
  int base;

  always @(posedge clk) if (rst_n && res_valid) n_pulse <= n_pulse + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sof, input logic eof,
                       input logic [31:0] d, input logic [2:0] lc);
    @(negedge clk);
    s_if.s_valid    = v;
    s_if.s_sof      = sof;
    s_if.s_eof      = eof;
    s_if.s_data     = d;
    s_if.s_last_cnt = lc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 32'h0, 3'd0);
  endtask

  task automatic note(input logic ok);
    if (ok) m_good = (m_good == 3) ? 3 : m_good + 1;
    else    m_bad  = (m_bad  == 3) ? 3 : m_bad + 1;
  endtask

  // checks the cycle right after the eof beat
  task automatic verdict(input string tag, input logic ok);
    idle(1);
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_ok"}, {31'd0, res_ok}, {31'd0, ok});
    note(ok);
  endtask

  task automatic chk_stats(input string tag);
`ifdef CRC_STATS_EN
    chk({tag, "_good"}, {30'd0, good_cnt}, m_good);
    chk({tag, "_bad"},  {30'd0, bad_cnt},  m_bad);
`else
    chk({tag, "_good"}, {30'd0, good_cnt}, 32'd0);
    chk({tag, "_bad"},  {30'd0, bad_cnt},  32'd0);
`endif
  endtask

  // "123456789" + FCS 26 39 F4 CB, 13 bytes, last beat has junk above byte0
  task automatic frame13(input int gap, input logic bad, input int nbeats);
    logic [31:0] b [4];
    b[0] = 32'h3433_3231;
    b[1] = bad ? 32'h3837_3634 : 32'h3837_3635;
    b[2] = 32'hF439_2639;
    b[3] = 32'hA5A5_A5CB;
    for (int k = 0; k < nbeats; k++) begin
      drive(1'b1, k == 0, k == 3, b[k], (k == 3) ? 3'd1 : 3'd4);
      if (k < nbeats - 1) idle(gap);
    end
  endtask

  initial begin
    s_if.s_valid = 1'b0; s_if.s_sof = 1'b0; s_if.s_eof = 1'b0;
    s_if.s_data = '0;    s_if.s_last_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_ok", {31'd0, res_ok}, 32'd0);
    chk_stats("rst");
    rst_n = 1'b1;
    idle(2);

    base = n_pulse;
    frame13(0, 1'b0, 4);
    verdict("good13", 1'b1);
    idle(1);
    chk("good13_pulse_end", {31'd0, res_valid}, 32'd0);
    chk("good13_hold", {31'd0, res_ok}, 32'd1);
    chk("good13_npulse", n_pulse - base, 32'd1);

    frame13(0, 1'b1, 4);
    verdict("bad13", 1'b0);
    idle(1);
    chk_stats("bad13");

    base = n_pulse;
    frame13(3, 1'b0, 4);
    verdict("gap13", 1'b1);
    idle(2);
    chk("gap13_npulse", n_pulse - base, 32'd1);

    base = n_pulse;
    frame13(0, 1'b0, 2);
    frame13(0, 1'b0, 4);
    verdict("abort", 1'b1);
    idle(2);
    chk("abort_npulse", n_pulse - base, 32'd1);
    chk_stats("abort");

    // 3 bytes: runt
    drive(1'b1, 1'b1, 1'b1, 32'hFF00_0000, 3'd3);
    verdict("runt", 1'b0);
    // FCS of empty payload is 00000000: a 4-byte zero frame is exactly MIN_BYTES and good
    drive(1'b1, 1'b1, 1'b1, 32'h0, 3'd0);
    verdict("lc0", 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h0, 3'd7);
    verdict("lc7", 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h0, 3'd4);
    verdict("lc4", 1'b1);
    idle(1);
    chk_stats("sat_a");

    base = n_pulse;
    drive(1'b1, 1'b0, 1'b1, 32'h0, 3'd4);
    idle(3);
    chk("nosof_npulse", n_pulse - base, 32'd0);

    frame13(0, 1'b0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    s_if.s_valid = 1'b0;
    @(negedge clk);
    m_good = 0; m_bad = 0;
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk_stats("midrst");
    rst_n = 1'b1;
    idle(1);
    base = n_pulse;
    frame13(0, 1'b0, 4);
    verdict("postrst", 1'b1);
    idle(2);
    chk("postrst_npulse", n_pulse - base, 32'd1);
    chk_stats("postrst");

    base = n_pulse;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0, 3'd4);
      if (k < 4) note(1'b1);
    end
    verdict("b2b", 1'b1);
    idle(2);
    chk("b2b_npulse", n_pulse - base, 32'd5);
    chk_stats("b2b");

    frame13(0, 1'b1, 4);
    verdict("bad_end", 1'b0);
    idle(2);
    chk_stats("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
